// File: rtl/riscv_mc_core.sv
// Multicycle RV32 integer core (FETCH/DECODE/EXEC/MEM/WB) with 32-entry regfile.
// Latency: branch/jal 3, ALU 4, sw 4, lw 5 core cycles plus memory wait cycles.
// Backpressure: imem_req/dmem_req are held with stable address/data until the matching valid.
//
// Ports:
//   CLOCK_50                 system clock (rising edge); rst synchronous active-high reset
//   imem_req/addr/rdata/valid  instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/rdata/valid  data load/store handshake (word aligned)
//   done / illegal           sticky halt flags (EOF word or unsupported encoding)
//   clock_count / instr_cnt  cycles since reset (frozen at done) / retired instructions
//
// Optional feature: define RISCV_MUL_EN to execute mul (funct7=0000001, funct3=000);
// without it that encoding halts the core as illegal and no multiplier is built.
module riscv_mc_core #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_valid,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_valid,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] clock_count,
  output logic [CNT_W-1:0] instr_cnt
);

  if (XLEN != 32) begin : g_xlen_check
    $error("riscv_mc_core: only XLEN=32 is supported");
  end

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ADD, K_SUB, K_MUL, K_ADDI, K_LUI, K_AUIPC, K_LW, K_SW,
    K_BEQ, K_BLT, K_JAL, K_ILL
  } kind_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic              done_q, illegal_q;
  logic [CNT_W-1:0]  cyc_q, ret_q;
  logic [XLEN-1:0]   rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;
  logic              retire;
  logic              ill_evt;

  // Instruction fields
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  kind_t       kind;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    kind = K_ILL;
    case (opc)
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      kind = K_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) kind = K_SUB;
`ifdef RISCV_MUL_EN
        else if (f3 == 3'b000 && f7 == 7'b0000001) kind = K_MUL;
`endif
      end
      7'b0010011: if (f3 == 3'b000) kind = K_ADDI;
      7'b0110111: kind = K_LUI;
      7'b0010111: kind = K_AUIPC;
      7'b0000011: if (f3 == 3'b010) kind = K_LW;
      7'b0100011: if (f3 == 3'b010) kind = K_SW;
      7'b1100011: begin
        if (f3 == 3'b000)      kind = K_BEQ;
        else if (f3 == 3'b100) kind = K_BLT;
      end
      7'b1101111: kind = K_JAL;
      default:    kind = K_ILL;
    endcase
  end

  logic        is_mem;
  logic [31:0] mem_addr;
  logic [31:0] pc4;

  assign is_mem   = (kind == K_LW) || (kind == K_SW);
  assign mem_addr = a_q + ((kind == K_SW) ? imm_s : imm_i);
  assign pc4      = pc_q + 32'd4;

  // Illegal encodings are caught in DECODE; misaligned accesses once the address exists in EXEC.
  assign ill_evt = ((state_q == S_DECODE) && (ir_q != EOF_WORD) && (kind == K_ILL)) ||
                   ((state_q == S_EXEC) && is_mem && (mem_addr[1:0] != 2'b00));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK_50) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (ir_q == EOF_WORD || kind == K_ILL) state_d = S_HALT;
        else                                   state_d = S_EXEC;
      end
      S_EXEC: begin
        case (kind)
          K_LW, K_SW:         state_d = (mem_addr[1:0] != 2'b00) ? S_HALT : S_MEM;
          K_BEQ, K_BLT, K_JAL: state_d = S_FETCH;
          default:            state_d = S_WB;
        endcase
      end
      S_MEM:    if (dmem_valid) state_d = (kind == K_SW) ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Request lines are masked during reset so an in-flight access is dropped immediately.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (!rst) begin
      imem_addr = pc_q;
      if (state_q == S_FETCH) imem_req = 1'b1;
      if (state_q == S_MEM) begin
        dmem_req   = 1'b1;
        dmem_we    = (kind == K_SW);
        dmem_addr  = alu_q;
        dmem_wdata = b_q;
      end
    end
  end

  assign done        = done_q;
  assign illegal     = illegal_q;
  assign clock_count = cyc_q;
  assign instr_cnt   = ret_q;

  // ---------------- datapath next state ----------------
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    a_d    = a_q;
    b_d    = b_q;
    tgt_d  = tgt_q;
    alu_d  = alu_q;
    mdr_d  = mdr_q;
    rf_we  = 1'b0;
    rf_wa  = rd;
    rf_wd  = '0;
    retire = 1'b0;
    case (state_q)
      S_FETCH: if (imem_valid) ir_d = imem_rdata;
      S_DECODE: begin
        a_d   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        b_d   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        tgt_d = pc_q + ((kind == K_JAL) ? imm_j : imm_b);
      end
      S_EXEC: begin
        case (kind)
          K_ADD:   alu_d = a_q + b_q;
          K_SUB:   alu_d = a_q - b_q;
`ifdef RISCV_MUL_EN
          K_MUL:   alu_d = a_q * b_q;
`endif
          K_ADDI:  alu_d = a_q + imm_i;
          K_LUI:   alu_d = imm_u;
          K_AUIPC: alu_d = pc_q + imm_u;
          K_LW, K_SW: alu_d = mem_addr;
          K_BEQ: begin
            pc_d   = (a_q == b_q) ? tgt_q : pc4;
            retire = 1'b1;
          end
          K_BLT: begin
            pc_d   = ($signed(a_q) < $signed(b_q)) ? tgt_q : pc4;
            retire = 1'b1;
          end
          K_JAL: begin
            rf_we  = 1'b1;
            rf_wd  = pc4;
            pc_d   = tgt_q;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_valid) begin
          if (kind == K_SW) begin
            pc_d   = pc4;
            retire = 1'b1;
          end else begin
            mdr_d = dmem_rdata;
          end
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        rf_wd  = (kind == K_LW) ? mdr_q : alu_q;
        pc_d   = pc4;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tgt_q     <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cyc_q     <= '0;
      ret_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tgt_q     <= tgt_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      done_q    <= done_q | (state_d == S_HALT);
      illegal_q <= illegal_q | ill_evt;
      if (!done_q) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)  ret_q <= ret_q + CNT_W'(1);
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule
